hall_period_meter: RTL and testbench

Upstream front end of the BLDC speed path: samples the three asynchronous Hall sensor lines, debounces them, validates the commutation sequence and measures the clock-cycle count between consecutive valid Hall transitions. Produces the signed `period_speed` word consumed by `pid_tuner` and the PID loop. The sign encodes rotation direction and the value saturates on stall.

---
 rtl/bldc_pkg.sv | 72 +++++++
 rtl/hall_debouncer.sv | 91 +++++++++
 rtl/hall_period_meter.sv | 108 ++++++++++
 tb/tb_hall_period_meter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared Hall-sensor definitions for the BLDC speed path: commutation states,
// sequence lookups and the period saturation limit.
package bldc_pkg;

  localparam logic [2:0] HALL_S1   = 3'b001;
  localparam logic [2:0] HALL_S2   = 3'b011;
  localparam logic [2:0] HALL_S3   = 3'b010;
  localparam logic [2:0] HALL_S4   = 3'b110;
  localparam logic [2:0] HALL_S5   = 3'b100;
  localparam logic [2:0] HALL_S6   = 3'b101;
  localparam logic [2:0] HALL_INV0 = 3'b000;
  localparam logic [2:0] HALL_INV7 = 3'b111;

  typedef enum logic [1:0] {
    EDGE_FWD,
    EDGE_REV,
    EDGE_BAD
  } hall_edge_e;

  // Largest positive value of a signed word of the given width.
  function automatic logic [31:0] period_max(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  function automatic logic [2:0] hall_next_fwd(input logic [2:0] s);
    logic [2:0] n;
    n = HALL_INV0;
    case (s)
      HALL_S1: n = HALL_S2;
      HALL_S2: n = HALL_S3;
      HALL_S3: n = HALL_S4;
      HALL_S4: n = HALL_S5;
      HALL_S5: n = HALL_S6;
      HALL_S6: n = HALL_S1;
      default: n = HALL_INV0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] hall_next_rev(input logic [2:0] s);
    logic [2:0] n;
    n = HALL_INV0;
    case (s)
      HALL_S1: n = HALL_S6;
      HALL_S6: n = HALL_S5;
      HALL_S5: n = HALL_S4;
      HALL_S4: n = HALL_S3;
      HALL_S3: n = HALL_S2;
      HALL_S2: n = HALL_S1;
      default: n = HALL_INV0;
    endcase
    return n;
  endfunction

  function automatic logic hall_is_valid(input logic [2:0] s);
    return (s != HALL_INV0) && (s != HALL_INV7);
  endfunction

  function automatic hall_edge_e hall_classify(input logic [2:0] prev, input logic [2:0] cur);
    hall_edge_e e;
    e = EDGE_BAD;
    if (hall_is_valid(prev) && hall_is_valid(cur)) begin
      if (hall_next_fwd(prev) == cur) begin
        e = EDGE_FWD;
      end else if (hall_next_rev(prev) == cur) begin
        e = EDGE_REV;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/hall_debouncer.sv
// Synchronizes the raw Hall lines and accepts a new state only after it has
// been stable for DEBOUNCE_CYCLES samples; accept_o is a registered strobe.
module hall_debouncer
  import bldc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] hall_i,
  output logic [2:0] state_o,
  output logic [2:0] prev_o,
  output logic       accept_o,
  output logic       first_o
);

  localparam logic [7:0] TARGET = 8'(DEBOUNCE_CYCLES);

  logic [2:0] sync1_q, sync2_q;
  logic [1:0] primed_q;
  logic [2:0] cand_q, cand_d;
  logic [2:0] state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       accept_q, accept_d;
  logic       firstacc_q, firstacc_d;

  // primed_q keeps the reset value of the synchronizer from being debounced
  // as if it were a real Hall sample.
  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    prev_d     = prev_q;
    first_d    = first_q;
    accept_d   = 1'b0;
    firstacc_d = 1'b0;
    if (primed_q[1]) begin
      if (cnt_q == TARGET) begin
        prev_d     = state_q;
        state_d    = cand_q;
        first_d    = 1'b0;
        accept_d   = 1'b1;
        firstacc_d = first_q;
        cnt_d      = 8'd0;
      end else if (first_q || (sync2_q != state_q)) begin
        if ((cnt_q != 8'd0) && (sync2_q == cand_q)) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cand_d = sync2_q;
          cnt_d  = 8'd1;
        end
      end else begin
        cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q    <= HALL_INV0;
      sync2_q    <= HALL_INV0;
      primed_q   <= 2'b00;
      cand_q     <= HALL_INV0;
      cnt_q      <= 8'd0;
      state_q    <= HALL_INV0;
      prev_q     <= HALL_INV0;
      first_q    <= 1'b1;
      accept_q   <= 1'b0;
      firstacc_q <= 1'b0;
    end else begin
      sync1_q    <= hall_i;
      sync2_q    <= sync1_q;
      primed_q   <= {primed_q[0], 1'b1};
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      accept_q   <= accept_d;
      firstacc_q <= firstacc_d;
    end
  end

  assign state_o  = state_q;
  assign prev_o   = prev_q;
  assign accept_o = accept_q;
  assign first_o  = firstacc_q;

endmodule

// File: rtl/hall_period_meter.sv
// Hall-sensor period meter: validates debounced commutation edges, measures the
// cycle count between them and publishes a signed, stall-saturated speed word.
module hall_period_meter
  import bldc_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         clk_div,
  input  logic                         reset,
  input  logic [2:0]                   hall,
  output logic signed [DATA_WIDTH-1:0] period_speed,
  output logic                         period_valid,
  output logic                         direction,
  output logic                         stall,
  output logic                         hall_fault
);

  localparam logic [DATA_WIDTH-1:0] MAX_PERIOD = DATA_WIDTH'(period_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] CNT_ONE    = DATA_WIDTH'(1);

  logic [2:0]            cur_state, prev_state;
  logic                  accept, first_acc;
  hall_edge_e            edge_class;
  logic [DATA_WIDTH-1:0] mag;

  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] speed_q, speed_d;
  logic                  armed_q, armed_d;
  logic                  valid_q, valid_d;
  logic                  dir_q, dir_d;
  logic                  stall_q, stall_d;
  logic                  fault_q, fault_d;

  hall_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i   (clk_div),
    .reset_i (reset),
    .hall_i  (hall),
    .state_o (cur_state),
    .prev_o  (prev_state),
    .accept_o(accept),
    .first_o (first_acc)
  );

  // An edge landing in the same cycle as saturation takes priority over stall.
  always_comb begin
    edge_class = hall_classify(prev_state, cur_state);
    mag        = (cnt_q == MAX_PERIOD) ? MAX_PERIOD : (cnt_q + CNT_ONE);
    cnt_d      = (cnt_q == MAX_PERIOD) ? cnt_q : (cnt_q + CNT_ONE);
    speed_d    = speed_q;
    armed_d    = armed_q;
    valid_d    = 1'b0;
    dir_d      = dir_q;
    stall_d    = stall_q;
    fault_d    = fault_q;
    if (accept) begin
      cnt_d = '0;
      if (!first_acc) begin
        if (edge_class == EDGE_BAD) begin
          fault_d = 1'b1;
          armed_d = 1'b0;
        end else begin
          dir_d   = (edge_class == EDGE_FWD);
          stall_d = 1'b0;
          armed_d = 1'b1;
          if (armed_q) begin
            speed_d = (edge_class == EDGE_FWD) ? mag : (~mag + CNT_ONE);
            valid_d = 1'b1;
          end
        end
      end
    end else if (armed_q && (cnt_q == MAX_PERIOD)) begin
      stall_d = 1'b1;
      valid_d = 1'b1;
      armed_d = 1'b0;
      speed_d = dir_q ? MAX_PERIOD : (~MAX_PERIOD + CNT_ONE);
    end
  end

  always_ff @(posedge clk_div) begin
    if (reset) begin
      cnt_q   <= '0;
      speed_q <= MAX_PERIOD;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      dir_q   <= 1'b1;
      stall_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      stall_q <= stall_d;
      fault_q <= fault_d;
    end
  end

  assign period_speed = speed_q;
  assign period_valid = valid_q;
  assign direction    = dir_q;
  assign stall        = stall_q;
  assign hall_fault   = fault_q;

endmodule

// File: tb/tb_hall_period_meter.sv
// Self-checking bench for hall_period_meter: directed and random Hall sequences
// scored against a segment-level model of edges, periods, stall and faults.
module tb_hall_period_meter;

  localparam int DW   = 16;
  localparam int DEB  = 4;
  localparam int MAXV = 32767;

  typedef struct {
    int speed;
    bit stall;
    int cyc;
  } pulse_t;

  logic                 clk_div;
  logic                 reset;
  logic [2:0]           hall;
  logic signed [DW-1:0] period_speed;
  logic                 period_valid;
  logic                 direction;
  logic                 stall;
  logic                 hall_fault;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  pulse_t expQ[$];
  pulse_t obsQ[$];

  logic [2:0] seqTab [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  logic [2:0] mState;
  int         mChangeCyc;
  bit         mArmed;
  bit         mDir;
  bit         mStall;
  bit         mFault;
  int         mSpeed;

  hall_period_meter #(
    .DATA_WIDTH(DW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_div     (clk_div),
    .reset       (reset),
    .hall        (hall),
    .period_speed(period_speed),
    .period_valid(period_valid),
    .direction   (direction),
    .stall       (stall),
    .hall_fault  (hall_fault)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  always @(posedge clk_div) cyc <= cyc + 1;

  // Every pulse is recorded with the cycle it appeared in, so latency and
  // pulse width are scored along with the value.
  always @(negedge clk_div) begin
    pulse_t p;
    if (!reset && period_valid) begin
      p.speed = int'(period_speed);
      p.stall = stall;
      p.cyc   = cyc;
      obsQ.push_back(p);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic int posOf(input logic [2:0] s);
    for (int i = 0; i < 6; i++) begin
      if (seqTab[i] == s) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] stepState(input logic [2:0] s, input bit fwd);
    int p;
    p = posOf(s);
    if (p < 0) return seqTab[0];
    return seqTab[fwd ? (p + 1) % 6 : (p + 5) % 6];
  endfunction

  task automatic emitStall();
    pulse_t e;
    mSpeed  = mDir ? MAXV : -MAXV;
    e.speed = mSpeed;
    e.stall = 1'b1;
    e.cyc   = mChangeCyc + DEB + 4 + MAXV + 1;
    expQ.push_back(e);
    mStall = 1'b1;
    mArmed = 1'b0;
  endtask

  // Drives a Hall state for n cycles; a change of state is scored by the model
  // from the sequence table and the cycle gap since the previous change.
  task automatic applyStimulus(input logic [2:0] s, input int n);
    int     gap, pa, pb, mag;
    bit     fwd;
    pulse_t e;
    if (s != mState) begin
      gap = cyc - mChangeCyc;
      if (mArmed && gap > MAXV + 1) emitStall();
      pa = posOf(mState);
      pb = posOf(s);
      if (pa >= 0 && pb >= 0 && (pb == (pa + 1) % 6 || pa == (pb + 1) % 6)) begin
        fwd = (pb == (pa + 1) % 6);
        if (mArmed) begin
          mag     = (gap > MAXV) ? MAXV : gap;
          mSpeed  = fwd ? mag : -mag;
          e.speed = mSpeed;
          e.stall = 1'b0;
          e.cyc   = cyc + DEB + 4;
          expQ.push_back(e);
        end
        mArmed = 1'b1;
        mDir   = fwd;
        mStall = 1'b0;
      end else begin
        mFault = 1'b1;
        mArmed = 1'b0;
      end
      mState     = s;
      mChangeCyc = cyc;
    end
    hall = s;
    repeat (n) @(posedge clk_div);
    #1;
  endtask

  task automatic compareModel(input string tag);
    int n;
    repeat (DEB + 6) @(posedge clk_div);
    #1;
    if (mArmed && (cyc - mChangeCyc) >= MAXV + DEB + 6) emitStall();
    checkOutput({tag, "_pulses"}, 32'(obsQ.size()), 32'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_speed"}, obsQ[i].speed, expQ[i].speed);
      checkOutput({tag, "_stallpulse"}, 32'(obsQ[i].stall), 32'(expQ[i].stall));
      checkOutput({tag, "_time"}, obsQ[i].cyc, expQ[i].cyc);
    end
    checkOutput({tag, "_dir"}, 32'(direction), 32'(mDir));
    checkOutput({tag, "_stall"}, 32'(stall), 32'(mStall));
    checkOutput({tag, "_fault"}, 32'(hall_fault), 32'(mFault));
    checkOutput({tag, "_level"}, int'(period_speed), mSpeed);
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk_div);
    #1;
    checkOutput("rst_speed", {16'h0, period_speed}, 32'h0000_7FFF);
    checkOutput("rst_valid", 32'(period_valid), 32'd0);
    checkOutput("rst_dir", 32'(direction), 32'd1);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_fault", 32'(hall_fault), 32'd0);
    reset      = 1'b0;
    mArmed     = 1'b0;
    mDir       = 1'b1;
    mStall     = 1'b0;
    mFault     = 1'b0;
    mSpeed     = MAXV;
    mChangeCyc = cyc;
  endtask

  initial begin
    logic [2:0] s;
    bit         fwd;
    int         r;
    hall   = 3'b001;
    mState = 3'b001;
    doReset(5);
    applyStimulus(mState, 50);

    // forward rotation, 1000 cycles per step
    for (int i = 0; i < 7; i++) applyStimulus(stepState(mState, 1'b1), 1000);
    checkOutput("fwd_value", int'(period_speed), 1000);
    checkOutput("fwd_dir", 32'(direction), 32'd1);
    compareModel("fwd");

    // reverse rotation, 500 cycles per step
    for (int i = 0; i < 6; i++) applyStimulus(stepState(mState, 1'b0), 500);
    checkOutput("rev_raw", {16'h0, period_speed}, 32'h0000_FE0C);
    checkOutput("rev_dir", 32'(direction), 32'd0);
    compareModel("rev");

    // steady rotation at the shortest supported spacing
    for (int i = 0; i < 6; i++) applyStimulus(stepState(mState, 1'b1), DEB + 1);
    compareModel("fast");

    // two-cycle glitch must be rejected
    while (mState != 3'b011) applyStimulus(stepState(mState, 1'b1), 600);
    compareModel("pre_glitch");
    hall = 3'b001;
    repeat (2) @(posedge clk_div);
    #1;
    applyStimulus(3'b011, 800);
    compareModel("glitch");

    // invalid state, then a valid sequence resumes
    applyStimulus(3'b111, 10);
    applyStimulus(3'b001, 700);
    for (int i = 0; i < 3; i++) applyStimulus(stepState(mState, 1'b1), 700);
    checkOutput("fault_sticky", 32'(hall_fault), 32'd1);
    compareModel("fault");

    // stall: hold one state well past saturation
    applyStimulus(stepState(mState, 1'b1), 700);
    applyStimulus(stepState(mState, 1'b1), 36000);
    checkOutput("stall_flag", 32'(stall), 32'd1);
    compareModel("stall");
    applyStimulus(stepState(mState, 1'b1), 700);
    checkOutput("stall_clear", 32'(stall), 32'd0);
    applyStimulus(stepState(mState, 1'b1), 700);
    compareModel("post_stall");

    // reset 300 cycles into a 1000-cycle period
    for (int i = 0; i < 2; i++) applyStimulus(stepState(mState, 1'b1), 1000);
    applyStimulus(stepState(mState, 1'b1), 300);
    doReset(5);
    applyStimulus(mState, 695);
    for (int i = 0; i < 3; i++) applyStimulus(stepState(mState, 1'b1), 1000);
    checkOutput("post_reset_value", int'(period_speed), 1000);
    compareModel("reset");

    // randomized walk with occasional arbitrary jumps
    fwd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        s = 3'($urandom_range(0, 7));
      end else begin
        if (r < 23) fwd = ~fwd;
        s = stepState(mState, fwd);
      end
      applyStimulus(s, int'($urandom_range(DEB + 1, 900)));
    end
    compareModel("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
